// File: rtl/lut_inverse_search.sv
// Inverse lookup over a monotonically non-increasing 128-entry LUT segment:
// returns the last offset whose entry is still >= target (bit-serial binary search).
module lut_inverse_search #(
    parameter int unsigned IDX_W = 8,
    parameter int unsigned VAL_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bank,
    input  logic [VAL_W-1:0] target,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] result_idx,
    output logic [VAL_W-1:0] result_val,
    output logic             exact,
    output logic             overflow,
    output logic [IDX_W-1:0] lut_index,
    input  logic [VAL_W-1:0] lut_value
);

    localparam int unsigned OFF_W = IDX_W - 1;
    localparam int unsigned BIT_W = (OFF_W > 1) ? $clog2(OFF_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK,
        S_SRCH,
        S_FIN,
        S_DONE
    } state_t;

    state_t             state, state_d;
    logic               bank_q, bank_d;
    logic [VAL_W-1:0]   target_q, target_d;
    logic [OFF_W-1:0]   k, k_d;
    logic [BIT_W-1:0]   bitc, bit_d;
    logic [OFF_W-1:0]   trial_c;
    logic               busy_d, done_d, exact_d, overflow_d;
    logic [IDX_W-1:0]   result_idx_d, lut_index_d;
    logic [VAL_W-1:0]   result_val_d;

    // Offset presented to the LUT for a given state / partial result / bit position
    function automatic logic [OFF_W-1:0] trial_of(input state_t s, input logic [OFF_W-1:0] kk,
                                                   input logic [BIT_W-1:0] b);
        logic [OFF_W-1:0] t;
        case (s)
            S_SRCH:  t = kk | (OFF_W'(1) << b);
            S_FIN:   t = kk;
            default: t = '0;
        endcase
        return t;
    endfunction

    // Next-state and next-output logic; lut_index is precomputed for the coming state
    always_comb begin
        state_d      = state;
        bank_d       = bank_q;
        target_d     = target_q;
        k_d          = k;
        bit_d        = bitc;
        exact_d      = exact;
        overflow_d   = overflow;
        result_idx_d = result_idx;
        result_val_d = result_val;
        trial_c      = trial_of(state, k, bitc);

        case (state)
            S_IDLE: begin
                if (start) begin
                    bank_d     = bank;
                    target_d   = target;
                    k_d        = '0;
                    exact_d    = 1'b0;
                    overflow_d = 1'b0;
                    state_d    = S_CHK;
                end
            end
            S_CHK: begin
                if (lut_value < target_q) begin
                    overflow_d = 1'b1;
                    k_d        = '0;
                    state_d    = S_FIN;
                end else begin
                    bit_d   = BIT_W'(OFF_W - 1);
                    state_d = S_SRCH;
                end
            end
            S_SRCH: begin
                if (lut_value >= target_q) begin
                    k_d = trial_c;
                end
                if (bitc == '0) begin
                    state_d = S_FIN;
                end else begin
                    bit_d = bitc - BIT_W'(1);
                end
            end
            S_FIN: begin
                result_idx_d = {bank_q, k};
                result_val_d = lut_value;
                exact_d      = (lut_value == target_q);
                state_d      = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        lut_index_d = (state_d == S_IDLE) ? '0 : {bank_d, trial_of(state_d, k_d, bit_d)};
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bank_q     <= 1'b0;
            target_q   <= '0;
            k          <= '0;
            bitc       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result_idx <= '0;
            result_val <= '0;
            exact      <= 1'b0;
            overflow   <= 1'b0;
            lut_index  <= '0;
        end else begin
            state      <= state_d;
            bank_q     <= bank_d;
            target_q   <= target_d;
            k          <= k_d;
            bitc       <= bit_d;
            busy       <= busy_d;
            done       <= done_d;
            result_idx <= result_idx_d;
            result_val <= result_val_d;
            exact      <= exact_d;
            overflow   <= overflow_d;
            lut_index  <= lut_index_d;
        end
    end

endmodule

// File: tb/tb_lut_inverse_search.sv
// Bench for lut_inverse_search: LUT model, linear-scan reference, per-cycle checks.
module tb_lut_inverse_search;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        bank = 1'b0;
    logic [23:0] target = '0;
    logic        busy, done, exact, overflow;
    logic [7:0]  result_idx, lut_index;
    logic [23:0] result_val, lut_value;

    int errors = 0;
    int checks = 0;
    logic [7:0] trace [1:8];

    lut_inverse_search #(.IDX_W(8), .VAL_W(24)) dut (
        .clk(clk), .rst(rst), .start(start), .bank(bank), .target(target),
        .busy(busy), .done(done), .result_idx(result_idx), .result_val(result_val),
        .exact(exact), .overflow(overflow), .lut_index(lut_index), .lut_value(lut_value)
    );

    always #5 clk = ~clk;

    // Seed table model: decreasing by 0x1000 per offset, upper bank offset by 0x800000
    function automatic logic [23:0] lut_f(input logic [7:0] i);
        logic [23:0] v;
        v = 24'h100000 + 24'(7'd127 - i[6:0]) * 24'h001000;
        if (i[7]) v = v + 24'h800000;
        return v;
    endfunction

    always_comb lut_value = lut_f(lut_index);

    // Reference: linear scan for the last offset still >= target
    function automatic void model(input logic b, input logic [23:0] t, output logic [7:0] idx,
                                  output logic [23:0] v, output logic ex, output logic ov);
        int best;
        best = 0;
        ov = (lut_f({b, 7'd0}) < t);
        if (!ov) begin
            for (int o = 0; o < 128; o++) begin
                if (lut_f({b, 7'(o)}) >= t) best = o;
            end
        end
        idx = {b, 7'(best)};
        v   = lut_f(idx);
        ex  = (v == t);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One search from the current (idle, negedge) point; spurious starts at cycles spur_a/spur_b
    task automatic run(input logic b, input logic [23:0] t, input int spur_a, input int spur_b);
        logic [7:0]  ei;
        logic [23:0] ev;
        logic        ee, eo;
        int          lat;
        model(b, t, ei, ev, ee, eo);
        lat = eo ? 3 : 10;
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
        chk("idle_lut_index", 32'(lut_index), 0);
        start  = 1'b1;
        bank   = b;
        target = t;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            start  = (c == spur_a) || (c == spur_b);
            bank   = 1'($urandom);
            target = 24'($urandom);
            if (c <= 8) trace[c] = lut_index;
            chk("busy", 32'(busy), 32'(c <= lat));
            chk("done", 32'(done), 32'(c == lat));
            if (c == 1) chk("chk_lut_index", 32'(lut_index), 32'({b, 7'd0}));
            if (c == lat - 1) chk("fin_lut_index", 32'(lut_index), 32'(ei));
            if (c == lat) begin
                chk("result_idx", 32'(result_idx), 32'(ei));
                chk("result_val", 32'(result_val), 32'(ev));
                chk("exact", 32'(exact), 32'(ee));
                chk("overflow", 32'(overflow), 32'(eo));
            end
        end
        start = 1'b0;
    endtask

    // Start a search, reset it mid-flight at cycle rc, confirm reset state and no done
    task automatic run_reset(input logic b, input logic [23:0] t, input int rc);
        logic ok;
        start  = 1'b1;
        bank   = b;
        target = t;
        for (int c = 1; c <= rc; c++) begin
            @(negedge clk);
            start = 1'b0;
            chk("rst_busy_before", 32'(busy), 1);
            if (c == rc) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_lut_index", 32'(lut_index), 0);
        chk("rst_result_idx", 32'(result_idx), 0);
        chk("rst_result_val", 32'(result_val), 0);
        chk("rst_exact", 32'(exact), 0);
        chk("rst_overflow", 32'(overflow), 0);
        ok = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) ok = 1'b0;
        end
        chk("no_done_after_reset", 32'(ok), 1);
    endtask

    initial begin
        logic [7:0]  exp_tr [1:8];
        logic        rb;
        logic [23:0] rt;
        exp_tr = '{8'h00, 8'h40, 8'h20, 8'h30, 8'h38, 8'h3C, 8'h3E, 8'h3F};

        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_result_idx", 32'(result_idx), 0);
        chk("reset_result_val", 32'(result_val), 0);
        chk("reset_exact", 32'(exact), 0);
        chk("reset_overflow", 32'(overflow), 0);
        chk("reset_lut_index", 32'(lut_index), 0);
        rst = 1'b0;
        @(negedge clk);

        // Exact hit at offset 0
        run(1'b0, 24'h17F000, 0, 0);
        chk("t1_idx", 32'(result_idx), 32'h00);
        chk("t1_val", 32'(result_val), 32'h17F000);
        chk("t1_exact", 32'(exact), 1);
        chk("t1_ovf", 32'(overflow), 0);
        repeat (2) @(negedge clk);

        // Between entries: probe sequence and result
        run(1'b0, 24'h140800, 0, 0);
        for (int i = 1; i <= 8; i++) chk("t2_trace", 32'(trace[i]), 32'(exp_tr[i]));
        chk("t2_idx", 32'(result_idx), 32'h3E);
        chk("t2_val", 32'(result_val), 32'h141000);
        chk("t2_exact", 32'(exact), 0);
        repeat (1) @(negedge clk);

        // Above entry 0: overflow, short latency
        run(1'b0, 24'h180000, 0, 0);
        chk("t3_ovf", 32'(overflow), 1);
        chk("t3_idx", 32'(result_idx), 32'h00);
        chk("t3_val", 32'(result_val), 32'h17F000);
        chk("t3_exact", 32'(exact), 0);
        repeat (3) @(negedge clk);

        // Upper bank, last entry
        run(1'b1, 24'h900000, 0, 0);
        chk("t4a_idx", 32'(result_idx), 32'hFF);
        chk("t4a_val", 32'(result_val), 32'h900000);
        chk("t4a_exact", 32'(exact), 1);
        run(1'b1, 24'h000001, 0, 0);
        chk("t4b_idx", 32'(result_idx), 32'hFF);
        chk("t4b_exact", 32'(exact), 0);
        chk("t4b_ovf", 32'(overflow), 0);
        @(negedge clk);

        // Starts while busy are ignored; start right after done is accepted
        run(1'b0, 24'h150000, 4, 10);
        chk("t5_idx", 32'(result_idx), 32'h2F);
        run(1'b1, 24'h955000, 0, 0);
        chk("t5b_idx", 32'(result_idx), 32'hAA);
        @(negedge clk);

        // Reset mid-search, then a normal search
        run_reset(1'b0, 24'h120000, 5);
        run(1'b0, 24'h120000, 0, 0);
        chk("t6_idx", 32'(result_idx), 32'h5F);

        // Randomized searches with random idle gaps
        for (int n = 0; n < 40; n++) begin
            rb = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       rt = lut_f({rb, 7'($urandom)});
                1:       rt = 24'($urandom_range(32'h0F0000, 32'h990000));
                2:       rt = lut_f({rb, 7'($urandom)}) + 24'd1;
                default: rt = 24'($urandom);
            endcase
            run(rb, rt, ($urandom_range(0, 1) == 1) ? 5 : 0, 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lut_inverse_search.md
Name: lut_inverse_search

Overview:
- Sequential inverse-lookup engine for the transcendental-function seed tables.
- Given a target value and a bank, it drives the index port of an external combinational LUT and runs a bit-serial binary search over the 128-entry monotonically decreasing segment selected by the bank bit.
- It returns the index of the last entry that is still >= target, so range reduction and argument recovery can map a function value back to a table position.
- It sits beside the seed LUT and owns that LUT's index port.

Parameters:
- IDX_W, 8, full LUT index width; MSB is the bank bit, lower IDX_W-1 bits are the segment offset.
- VAL_W, 24, LUT entry width and target width, unsigned fixed point.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- bank  in  1  segment select; captured on an accepted start.
- target  in  VAL_W  value to locate; captured on an accepted start.
- busy  out  1  high from the cycle after an accepted start until DONE is left.
- done  out  1  one-cycle pulse; result outputs are valid.
- result_idx  out  IDX_W  {bank, offset} of the found entry.
- result_val  out  VAL_W  LUT value at result_idx.
- exact  out  1  result_val == target.
- overflow  out  1  target > entry at offset 0; result offset forced to 0.
- lut_index  out  IDX_W  index to external LUT.
- lut_value  in  VAL_W  external LUT data; combinational, zero latency, sampled the same cycle lut_index is driven.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values: state IDLE, busy 0, done 0, result_idx 0, result_val 0, exact 0, overflow 0, lut_index 0. Internal offset k and bit counter are cleared.
- Table assumption: entries are non-increasing in offset within each segment. Unsigned compare, full VAL_W width, no rounding.
- lut_index = {bank_q, trial}; trial is state dependent. In IDLE, lut_index = 0.
- IDLE: start=1 captures bank and target, clears k and the flags, goes to CHK. No other input has effect.
- CHK (1 cycle): trial = 0.
  - If lut_value < target_q: set overflow, k = 0, go to FIN.
  - Otherwise go to SRCH with bit = IDX_W-2 (6).
- SRCH (IDX_W-1 = 7 cycles, bit 6 down to 0): trial = k | (1<<bit).
  - If lut_value >= target_q, k <= trial.
  - On bit 0, go to FIN.
- FIN (1 cycle): trial = k. Register result_idx = {bank_q, k}, result_val = lut_value, exact = (lut_value == target_q). Go to DONE.
- DONE (1 cycle): done = 1, busy = 1. Return to IDLE; start is ignored in DONE.
- Latency: with start accepted at edge 0, done is high in cycle 10 (normal path) or cycle 3 (overflow path). busy covers cycles 1..10 (or 1..3).
- Results and flags hold until the next accepted start clears the flags. result_idx and result_val hold until overwritten in FIN.
- start while busy: ignored, not queued.
- Changes to target or bank after acceptance have no effect.
- Target <= entry 127: k = 127, a valid result, not a flag.
- Equal entries: the largest offset among the equal run is returned.
- Reset asserted in any state: next cycle is IDLE with all reset values. An in-flight search is discarded and done is not asserted.
- rst and start in the same cycle: rst wins.
- No combinational path from start or target to lut_index. lut_index depends only on registered state and bank_q.

Test Plan:
Bench LUT model: lut(i) = 0x100000 + (127 - i[6:0])*0x1000, plus 0x800000 when i[7]=1.
1. bank=0, target=0x17F000 -> done at cycle 10; result_idx=0x00, result_val=0x17F000, exact=1, overflow=0.
2. bank=0, target=0x140800 -> result_idx=0x3E (62), result_val=0x141000, exact=0, overflow=0. lut_index sequence across CHK and SRCH is 0x00, 0x40, 0x20, 0x30, 0x38, 0x3C, 0x3E, 0x3F.
3. bank=0, target=0x180000 -> overflow=1, result_idx=0x00, result_val=0x17F000, exact=0, done at cycle 3.
4. bank=1, target=0x900000 -> result_idx=0xFF, result_val=0x900000, exact=1; target=0x000001 -> result_idx=0xFF, exact=0.
5. start pulsed at cycles 4 and 10 of a running search -> both ignored; a single done and an unchanged result. A start one cycle after done is accepted.
6. rst asserted at cycle 5 of a search -> cycle 6 shows busy=0, done=0, lut_index=0, all results 0, and no done pulse follows. A new start then completes normally.
